// File: rtl/ram_bist_sequencer_pkg.sv
// Shared definitions for the RAM BIST sequencer: FSM encoding and default RAM geometry
// (the same geometry the BIST and the RAM model use).
package ram_bist_sequencer_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    FILL_SETUP,
    FILL_STROBE,
    FILL_HOLD,
    START,
    WAIT_RISE,
    RUN,
    DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ram_bist_sequencer_if.sv
// Control, RAM-pin and BIST handshake bundle between the sequencer (master) and its
// surroundings (slave: requester, RAM pin mux and BIST engine).
interface ram_bist_sequencer_if
  import ram_bist_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              go;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic              ram_owner;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_cs;
  logic              ram_we;
  logic              ram_oe;
  logic              bist_start;
  logic              bist_marching;
  logic              bist_success;

  modport master (
    input  go, bist_marching, bist_success,
    output busy, done, pass, timeout,
    output ram_owner, ram_addr, ram_data, ram_cs, ram_we, ram_oe,
    output bist_start
  );

  modport slave (
    output go, bist_marching, bist_success,
    input  busy, done, pass, timeout,
    input  ram_owner, ram_addr, ram_data, ram_cs, ram_we, ram_oe,
    input  bist_start
  );

endinterface

// File: rtl/ram_bist_sequencer_fill_pattern.sv
// Fill pattern generator: word(a) = SEED + a, wrapping modulo 2**DATA_W.
// Kept separate so a different preload pattern can be dropped in.
module ram_fill_pattern
  import ram_bist_sequencer_pkg::*;
#(
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);

  assign word = SEED + DATA_W'(addr);

endmodule

// File: rtl/ram_bist_sequencer.sv
// RAM BIST sequencer: preloads every RAM word with a pattern, pulses the BIST start,
// then watches the march with a watchdog and latches pass/timeout.
module ram_bist_sequencer
  import ram_bist_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SEED       = DATA_W'(1),
  parameter int                START_WAIT = 4,
  parameter int                RUN_MAX    = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  ram_bist_sequencer_if.master bus
);

  localparam int                WD_W      = $clog2(max_int(START_WAIT, RUN_MAX)) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [WD_W-1:0]   START_LIM = WD_W'(START_WAIT - 1);
  localparam logic [WD_W-1:0]   RUN_LIM   = WD_W'(RUN_MAX - 1);

  state_t            state_p0, state_nxt;
  logic [ADDR_W-1:0] addr_p0, addr_nxt;
  logic [WD_W-1:0]   wd_p0, wd_nxt;
  logic              pass_p0, pass_nxt;
  logic              tmo_p0, tmo_nxt;
  logic [DATA_W-1:0] word;
  logic              fill;

  ram_fill_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .addr (addr_p0),
    .word (word)
  );

  // ---- stage p0: control state, fill address, watchdog, result latches ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      addr_p0  <= '0;
      wd_p0    <= '0;
      pass_p0  <= 1'b0;
      tmo_p0   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      addr_p0  <= addr_nxt;
      wd_p0    <= wd_nxt;
      pass_p0  <= pass_nxt;
      tmo_p0   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    addr_nxt  = addr_p0;
    wd_nxt    = wd_p0;
    pass_nxt  = pass_p0;
    tmo_nxt   = tmo_p0;
    case (state_p0)
      IDLE, DONE: begin
        if (bus.go) begin
          state_nxt = FILL_SETUP;
          addr_nxt  = '0;
          pass_nxt  = 1'b0;
          tmo_nxt   = 1'b0;
        end
      end
      FILL_SETUP:  state_nxt = FILL_STROBE;
      FILL_STROBE: state_nxt = FILL_HOLD;
      FILL_HOLD: begin
        // The increment wraps the counter back to 0 after the last word.
        addr_nxt  = addr_p0 + 1'b1;
        state_nxt = (addr_p0 == LAST_ADDR) ? START : FILL_SETUP;
      end
      START: begin
        state_nxt = WAIT_RISE;
        wd_nxt    = '0;
      end
      WAIT_RISE: begin
        if (bus.bist_marching) begin
          state_nxt = RUN;
          wd_nxt    = '0;
        end else if (wd_p0 == START_LIM) begin
          state_nxt = DONE;
          pass_nxt  = 1'b0;
          tmo_nxt   = 1'b1;
        end else begin
          wd_nxt = wd_p0 + 1'b1;
        end
      end
      RUN: begin
        if (!bus.bist_marching) begin
          state_nxt = DONE;
          pass_nxt  = bus.bist_success;
          tmo_nxt   = 1'b0;
        end else if (wd_p0 == RUN_LIM) begin
          state_nxt = DONE;
          pass_nxt  = 1'b0;
          tmo_nxt   = 1'b1;
        end else begin
          wd_nxt = wd_p0 + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fill = (state_p0 == FILL_SETUP) || (state_p0 == FILL_STROBE) ||
                (state_p0 == FILL_HOLD);

  // ---- stage p1: registered outputs decoded from the p0 state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.ram_owner  <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_data   <= '0;
      bus.ram_cs     <= 1'b0;
      bus.ram_we     <= 1'b0;
      bus.ram_oe     <= 1'b0;
      bus.bist_start <= 1'b0;
    end else begin
      bus.busy       <= (state_p0 != IDLE) && (state_p0 != DONE);
      bus.done       <= (state_p0 == DONE);
      bus.pass       <= pass_p0;
      bus.timeout    <= tmo_p0;
      bus.ram_owner  <= fill;
      bus.ram_addr   <= fill ? addr_p0 : '0;
      bus.ram_data   <= fill ? word : '0;
      bus.ram_cs     <= fill;
      bus.ram_we     <= (state_p0 == FILL_STROBE);
      bus.ram_oe     <= 1'b0;
      bus.bist_start <= (state_p0 == START);
    end
  end

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Bench for ram_bist_sequencer: behavioural RAM and BIST model, table-driven and
// randomized sequences compared against an outcome model derived from the fill/timeout rules.
module tb_ram_bist_sequencer;

  localparam int          START_WAIT = 4;
  localparam int          RUN_MAX    = 64;
  localparam int          DEPTH      = 4;
  localparam int          FILL_LAT   = 3 * DEPTH;
  localparam logic [2:0]  SEED       = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  ram_bist_sequencer_if #(.ADDR_W(2), .DATA_W(3)) bus ();

  ram_bist_sequencer #(
    .ADDR_W(2), .DATA_W(3), .SEED(SEED), .START_WAIT(START_WAIT), .RUN_MAX(RUN_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural RAM, BIST model and pin monitor
  logic [2:0] mem [DEPTH];
  int   wr_q [$];
  int   inv_err = 0;
  int   start_cyc = -1;
  int   cfg_delay = 2;
  int   cfg_len = 24;
  bit   cfg_stuck = 0;
  int   m_phase = 0;
  int   m_cnt = 0;

  function automatic bit mem_ok();
    for (int a = 0; a < DEPTH; a++)
      if (int'(mem[a]) != (int'(SEED) + a) % 8) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(negedge clk);
    if (bus.ram_we && !bus.ram_cs) inv_err++;
    if (!bus.ram_owner && (bus.ram_cs || bus.ram_we)) inv_err++;
    if (bus.ram_oe) inv_err++;
    if (bus.ram_cs && bus.ram_we) begin
      wr_q.push_back(int'(bus.ram_addr) * 16 + int'(bus.ram_data));
      mem[bus.ram_addr] = bus.ram_data | ((cfg_stuck && bus.ram_addr == 2'd1) ? 3'b001 : 3'b000);
    end
    if (m_phase == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        bus.bist_marching = 1'b1;
        m_phase = 2;
        m_cnt = cfg_len;
      end
    end else if (m_phase == 2) begin
      m_cnt--;
      if (m_cnt == 0) begin
        bus.bist_marching = 1'b0;
        bus.bist_success = mem_ok();
        m_phase = 0;
      end
    end
    if (bus.bist_start) begin
      start_cyc = cyc;
      bus.bist_success = 1'b0;
      if (cfg_delay == 0) begin
        bus.bist_marching = 1'b1;
        m_phase = 2;
        m_cnt = cfg_len;
      end else if (cfg_delay > 0) begin
        m_phase = 1;
        m_cnt = cfg_delay;
      end
    end
  end

  // Outcome model: delay < 0 means the BIST never answers
  function automatic void ref_model(input int d, input int l, input bit stuck,
                                    output bit p, output bit t);
    if (d < 0 || d >= START_WAIT || l > RUN_MAX) begin
      p = 1'b0;
      t = 1'b1;
    end else begin
      p = !stuck;
      t = 1'b0;
    end
  endfunction

  task automatic pulse_go(output int p);
    @(negedge clk);
    bus.go = 1'b1;
    p = cyc + 1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!bus.done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s.done_seen", tag), bus.done, 1);
  endtask

  task automatic check_fill(input string tag);
    bit ok = (wr_q.size() == DEPTH);
    for (int a = 0; a < DEPTH; a++)
      if (ok && wr_q[a] != a * 16 + (int'(SEED) + a) % 8) ok = 1'b0;
    check($sformatf("%s.fill_writes(n=%0d)", tag, wr_q.size()), ok, 1);
  endtask

  task automatic prep(input int d, input int l, input bit stuck);
    int k = 0;
    while (m_phase != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    for (int a = 0; a < DEPTH; a++) mem[a] = 3'd0;
    cfg_delay = d;
    cfg_len = l;
    cfg_stuck = stuck;
    wr_q.delete();
    start_cyc = -1;
  endtask

  task automatic run_seq(input string tag, input int d, input int l, input bit stuck,
                         input bit exp_p, input bit exp_t);
    int p;
    int dc;
    prep(d, l, stuck);
    pulse_go(p);
    @(negedge clk);
    check($sformatf("%s.restart{busy,done,pass,tmo}", tag),
          {bus.busy, bus.done, bus.pass, bus.timeout}, 4'b1000);
    wait_done(tag);
    dc = cyc;
    check($sformatf("%s.pass", tag), bus.pass, exp_p);
    check($sformatf("%s.timeout", tag), bus.timeout, exp_t);
    check($sformatf("%s.busy_in_done", tag), bus.busy, 0);
    check_fill(tag);
    check($sformatf("%s.start_cycle", tag), start_cyc, p + FILL_LAT + 1);
    if (d < 0) check($sformatf("%s.wait_rise_timeout_lat", tag), dc - start_cyc, 5);
  endtask

  typedef struct {
    int d;
    int l;
    bit stuck;
    bit exp_p;
    bit exp_t;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int p;
    int k;
    bit rp;
    bit rt;

    tbl[0] = '{d: 2,  l: 24, stuck: 0, exp_p: 1, exp_t: 0};
    tbl[1] = '{d: 2,  l: 24, stuck: 1, exp_p: 0, exp_t: 0};
    tbl[2] = '{d: -1, l: 24, stuck: 0, exp_p: 0, exp_t: 1};
    tbl[3] = '{d: 0,  l: 1,  stuck: 0, exp_p: 1, exp_t: 0};
    tbl[4] = '{d: 3,  l: 60, stuck: 0, exp_p: 1, exp_t: 0};
    tbl[5] = '{d: 1,  l: 70, stuck: 0, exp_p: 0, exp_t: 1};
    tbl[6] = '{d: 8,  l: 5,  stuck: 0, exp_p: 0, exp_t: 1};

    bus.go = 1'b0;
    bus.bist_marching = 1'b0;
    bus.bist_success = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.pass, bus.timeout, bus.ram_owner,
          bus.ram_cs, bus.ram_we, bus.ram_oe, bus.bist_start, bus.ram_addr, bus.ram_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {bus.busy, bus.done}, 0);

    for (int i = 0; i < 7; i++)
      run_seq($sformatf("vec%0d", i), tbl[i].d, tbl[i].l, tbl[i].stuck, tbl[i].exp_p, tbl[i].exp_t);

    // Reset in the middle of the write strobe for address 2
    prep(2, 24, 0);
    pulse_go(p);
    k = 0;
    while (!(bus.ram_we && bus.ram_addr == 2'd2) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid.reach_strobe_a2", bus.ram_we, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.pins_drop", {bus.ram_owner, bus.ram_cs, bus.ram_we, bus.busy,
          bus.ram_addr, bus.ram_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq("rst_mid.refill", 2, 24, 0, 1, 0);

    // go during RUN is ignored; go in DONE restarts and re-latches pass
    prep(2, 24, 0);
    pulse_go(p);
    k = 0;
    while (!bus.bist_marching && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    pulse_go(p);
    repeat (2) @(negedge clk);
    check("go_in_run.ignored{busy,done,owner}", {bus.busy, bus.done, bus.ram_owner}, 3'b100);
    wait_done("go_in_run");
    check("go_in_run.pass", bus.pass, 1);
    check("go_in_run.no_refill", wr_q.size(), DEPTH);
    run_seq("go_in_done", 2, 24, 0, 1, 0);

    // Randomized BIST behaviour against the outcome model
    for (int i = 0; i < 8; i++) begin
      int d = int'($urandom_range(0, 4));
      int l = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(70, 90));
      bit s = bit'($urandom_range(0, 1));
      if (d == 4) d = -1;
      ref_model(d, l, s, rp, rt);
      run_seq($sformatf("rnd%0d(d=%0d,l=%0d,s=%0d)", i, d, l, s), d, l, s, rp, rt);
    end

    check("pin_invariants", inv_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got %0d cycles expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule
